pcie_lane_en_seq: RTL and testbench
===================================

# pcie_lane_en_seq

Sequencer that drives the four lane-group enables (`en0`..`en3`) consumed by the PCIe lane pass-through that sits between the BlueNoC PCIe core and the serial pins. It takes a requested number of active lane groups and raises or lowers the enables one group at a time, waiting a fixed settle interval after each change. Completion is reported with a one-cycle pulse. The block lives in the pcie-bluenoc physical-device directory, beside the lane pass-through.

## Interface
- `SETTLE_CYCLES`, default 256: wait after each enable change, in cycles. Must be at least 1.
- `CNT_W`, default 16: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request strobe.
- `req_groups`  in  3  target number of enabled groups, 0..4. Values 5..7 are clamped to 4.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `en0`  out  1  group 0 enable (lane 0).
- `en1`  out  1  group 1 enable (lane 1).
- `en2`  out  1  group 2 enable (lanes 2-3).
- `en3`  out  1  group 3 enable (lanes 4-7).
- `lanes_on`  out  3  number of enable bits currently set, 0..4.
- `busy`  out  1  high whenever not in IDLE.
- `done`  out  1  one-cycle pulse when a request completes.

## Operation
- Enables are thermometer-coded. `en[k]` is high iff k < `lanes_on`. No other pattern is ever driven.
- States:
  - IDLE: waits for a request.
  - STEP: changes exactly one enable bit.
  - WAIT: runs the settle count.
- Request acceptance: a request is accepted when `req_valid` and `req_ready` are both high. The clamped target is latched at acceptance. A request presented while busy is not accepted. The requester must hold `req_valid` until it sees `req_ready`.
- IDLE -> STEP on acceptance if the target differs from `lanes_on`.
- IDLE -> IDLE on acceptance if the target equals `lanes_on`. In this case `done` pulses on the next cycle and no enable changes.
- STEP:
  - If target > `lanes_on`, set the next bit up, `en[lanes_on]`.
  - Otherwise clear the top bit, `en[lanes_on-1]`.
  - Increment or decrement `lanes_on` to match.
  - Load the counter with SETTLE_CYCLES-1, then go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero and `lanes_on` ≠ target: go to STEP.
  - Counter zero and `lanes_on` = target: go to IDLE with `done`=1.
- Ordering: raising runs in ascending group order; lowering runs in descending order.
- Retargeting mid-sequence is not supported. The latched target is held until `done`.
- Reset values: all enables 0, `lanes_on`=0, `busy`=0, `done`=0, `req_ready`=1, state IDLE, counter 0.
- Reset mid-sequence: the state returns to IDLE and all enables drop to 0 on the same edge. No lowering sequence is run.

## Timing
- Every output is registered.
- With the handshake on the edge at cycle 0:
  - The first enable change is visible at cycle 1.
  - Successive enable changes are exactly SETTLE_CYCLES+1 cycles apart.
  - `done` rises SETTLE_CYCLES+1 cycles after the last change, and `req_ready` rises on that same cycle.
- A new request may be accepted on the `done` cycle itself.
- Total latency for N steps is N·(SETTLE_CYCLES+1)+1 cycles. For zero steps it is 1 cycle.
- `busy` is high from cycle 1 until the cycle before `done`.
- `lanes_on` updates on the same edge as the corresponding enable bit.

## Structure
- Shared package `pcie_lane_pkg` holds:
  - the state enum (IDLE, STEP, WAIT);
  - `LANE_GROUPS` = 4;
  - the group-to-lane map constants;
  - a clamp function for `req_groups`.
- One natural sub-module, `pcie_settle_timer`:
  - loadable down-counter of width CNT_W;
  - ports: `load`, `zero`.
- The FSM, target register and thermometer register live in the top level.

## Test plan
Scenarios 1-4 use SETTLE_CYCLES=4.
1. From reset, request 2 at cycle 0 -> `en0` high at cycle 1, `en1` high at cycle 6, `done` at cycle 11, `lanes_on`=2, `en2`=`en3`=0.
2. From 4 groups, request 1 -> `en3` drops first, then `en2`, then `en1`, changes 5 cycles apart; `en0` stays high; `done` one pulse; final `lanes_on`=1.
3. With 2 groups on, request 2 -> no enable toggles, `done` at cycle 1, `busy` never high.
4. Request 7 from 0 -> clamped to 4, all four enables raised in order, `done` at cycle 21.
5. Assert `req_valid` with value 0 while busy from scenario 1 -> not accepted, `req_ready`=0, enables unaffected; it is accepted on the `done` cycle and lowering starts on the next cycle.
6. Assert `RST` while in WAIT with 3 groups on -> on the next edge all enables are 0, `lanes_on`=0, `req_ready`=1, and `done` is not pulsed.

Source files
------------

// File: rtl/pcie_lane_pkg.sv
// Shared types and helpers for the PCIe lane-group enable sequencer.
package pcie_lane_pkg;

  // Sequencer states: IDLE accepts requests, STEP follows each single-bit
  // enable change, WAIT runs the settle interval.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int LANE_GROUPS = 4;

  // Group-to-lane map: group 0 -> lane 0, group 1 -> lane 1,
  // group 2 -> lanes 2-3, group 3 -> lanes 4-7.
  function automatic int unsigned group_first_lane(input int unsigned group);
    case (group)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned group_lane_count(input int unsigned group);
    case (group)
      0:       return 1;
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  // Requests above the number of groups saturate to all groups on.
  function automatic logic [2:0] clamp_groups(input logic [2:0] groups);
    return (groups > 3'(LANE_GROUPS)) ? 3'(LANE_GROUPS) : groups;
  endfunction

endpackage

// File: rtl/pcie_settle_timer.sv
// Loadable down-counter that times the settle interval after an enable change.
module pcie_settle_timer #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement only while enabled and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pcie_lane_en_seq.sv
// Lane-group enable sequencer: walks a thermometer-coded enable vector up or
// down one group at a time toward a requested group count, settling after
// each change and pulsing done on completion.
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and the requester
// holds req_valid (and req_groups) until that edge.
module pcie_lane_en_seq
  import pcie_lane_pkg::*;
#(
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  input  logic [2:0] req_groups,
  output logic       req_ready,
  output logic       en0,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic [2:0] lanes_on,
  output logic       busy,
  output logic       done,
  output state_t     fsm_state
);

  state_t     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic [3:0] therm_q;
  logic [2:0] lanes_q;
  logic       done_q, done_d;
  logic       do_step;
  logic       step_up;
  logic       timer_zero;
  logic [2:0] req_target;

  assign req_target = clamp_groups(req_groups);

  // The enable change is registered on the edge that enters STEP, so it is
  // visible while STEP is the current state; the timer is loaded on the same
  // edge and only counts in WAIT, giving SETTLE_CYCLES+1 cycles per step.
  pcie_settle_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (CNT_W'(SETTLE_CYCLES - 1))
  ) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .load (do_step),
    .dec  (state_q == S_WAIT),
    .zero (timer_zero)
  );

  // Next-state, step request, target latch and done decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    done_d   = 1'b0;
    do_step  = 1'b0;
    step_up  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          if (req_target != lanes_q) begin
            state_d = S_STEP;
            do_step = 1'b1;
            step_up = (req_target > lanes_q);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_STEP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_zero) begin
          if (lanes_q != target_q) begin
            state_d = S_STEP;
            do_step = 1'b1;
            step_up = (target_q > lanes_q);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, target and done registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      target_q <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  // Thermometer register: shifting in a one raises the next group up,
  // shifting right drops the top group, so only thermometer codes exist.
  always_ff @(posedge CLK) begin
    if (RST) begin
      therm_q <= 4'b0000;
      lanes_q <= 3'd0;
    end else if (do_step) begin
      if (step_up) begin
        therm_q <= {therm_q[2:0], 1'b1};
        lanes_q <= lanes_q + 3'd1;
      end else begin
        therm_q <= {1'b0, therm_q[3:1]};
        lanes_q <= lanes_q - 3'd1;
      end
    end
  end

  assign en0       = therm_q[0];
  assign en1       = therm_q[1];
  assign en2       = therm_q[2];
  assign en3       = therm_q[3];
  assign lanes_on  = lanes_q;
  assign done      = done_q;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pcie_lane_en_seq.sv
// Bench for pcie_lane_en_seq with a short settle interval. Expected traces
// come from a timeline model: step i of a request lands at cycle
// 1+(i-1)*(SETTLE+1) and done lands at N*(SETTLE+1)+1.
module tb_pcie_lane_en_seq;
  import pcie_lane_pkg::*;

  localparam int SETTLE = 4;
  localparam int PERIOD = SETTLE + 1;

  logic       CLK;
  logic       RST;
  logic       req_valid;
  logic [2:0] req_groups;
  logic       req_ready;
  logic       en0, en1, en2, en3;
  logic [2:0] lanes_on;
  logic       busy;
  logic       done;
  state_t     fsm_state;

  int vectors;
  int miscompares;
  int level;

  pcie_lane_en_seq #(
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_groups (req_groups),
    .req_ready  (req_ready),
    .en0        (en0),
    .en1        (en1),
    .en2        (en2),
    .en3        (en3),
    .lanes_on   (lanes_on),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp_req(input int raw);
    return (raw > 4) ? 4 : raw;
  endfunction

  // Present a request and return just after the accepting edge (cycle 1).
  task automatic send(input int raw, output bit ok);
    int budget;
    budget = 0;
    @(negedge CLK);
    req_valid  = 1'b1;
    req_groups = 3'(raw);
    while (!req_ready && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Check every cycle of one request, from cycle 1 through the done cycle.
  // Optionally queue a follow-on request from cycle 2 onward.
  task automatic run_model(input int from_l, input int to_l,
                           input bit nxt_valid, input int nxt_raw);
    logic [2:0] exp_q[$];
    logic [2:0] el;
    logic [3:0] exp_en;
    logic       exp_busy;
    int n, last, ch;
    n    = (to_l > from_l) ? (to_l - from_l) : (from_l - to_l);
    last = (n == 0) ? 1 : n * PERIOD + 1;
    for (int k = 1; k <= last; k++) begin
      ch = (n == 0) ? 0 : ((k - 1) / PERIOD + 1);
      if (ch > n) ch = n;
      exp_q.push_back(3'((to_l >= from_l) ? from_l + ch : from_l - ch));
    end
    for (int k = 1; k <= last; k++) begin
      el       = exp_q.pop_front();
      exp_en   = 4'((1 << el) - 1);
      exp_busy = (n != 0) && (k < last);
      vectors++;
      if ({en3, en2, en1, en0} !== exp_en || lanes_on !== el) begin
        miscompares++;
        $display("FAIL enables %0d->%0d cycle %0d: en=%b lanes_on=%0d required en=%b lanes_on=%0d",
                 from_l, to_l, k, {en3, en2, en1, en0}, lanes_on, exp_en, el);
      end
      vectors++;
      if (done !== (k == last)) begin
        miscompares++;
        $display("FAIL done %0d->%0d cycle %0d: got %b required %b",
                 from_l, to_l, k, done, (k == last));
      end
      vectors++;
      if (busy !== exp_busy || req_ready !== !exp_busy) begin
        miscompares++;
        $display("FAIL busy_ready %0d->%0d cycle %0d: busy=%b ready=%b required busy=%b ready=%b",
                 from_l, to_l, k, busy, req_ready, exp_busy, !exp_busy);
      end
      if (nxt_valid && k == 2) begin
        req_valid  = 1'b1;
        req_groups = 3'(nxt_raw);
      end
      if (k < last) begin
        @(posedge CLK);
        #1;
      end
    end
    level = to_l;
  endtask

  task automatic request(input int raw);
    bit ok;
    send(raw, ok);
    if (ok) run_model(level, clamp_req(raw), 1'b0, 0);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    req_valid = 1'b0;
    req_groups = 3'd0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if ({en3, en2, en1, en0} !== 4'b0000 || lanes_on !== 3'd0 || busy !== 1'b0 ||
        done !== 1'b0 || req_ready !== 1'b1 || fsm_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset_values en=%b lanes_on=%0d busy=%b done=%b ready=%b required 0000/0/0/0/1",
               {en3, en2, en1, en0}, lanes_on, busy, done, req_ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    level = 0;
  endtask

  task automatic test_raise;
    request(2);
  endtask

  task automatic test_same_level;
    request(2);
    @(posedge CLK);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || lanes_on !== 3'd2) begin
      miscompares++;
      $display("FAIL same_level_after done=%b busy=%b lanes_on=%0d required 0/0/2",
               done, busy, lanes_on);
    end
  endtask

  task automatic test_lower;
    request(4);
    request(1);
  endtask

  task automatic test_clamp;
    request(0);
    request(7);
  endtask

  task automatic test_back_to_back;
    bit ok;
    request(0);
    send(2, ok);
    if (ok) begin
      run_model(0, 2, 1'b1, 0);
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      run_model(2, 0, 1'b0, 0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    request(0);
    send(3, ok);
    if (ok) begin
      repeat (12) @(posedge CLK);
      #1;
      vectors++;
      if (lanes_on !== 3'd3 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_wait lanes_on=%0d busy=%b required 3/1", lanes_on, busy);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      vectors++;
      if ({en3, en2, en1, en0} !== 4'b0000 || lanes_on !== 3'd0 || req_ready !== 1'b1 ||
          done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid en=%b lanes_on=%0d ready=%b done=%b busy=%b required 0000/0/1/0/0",
                 {en3, en2, en1, en0}, lanes_on, req_ready, done, busy);
      end
      @(negedge CLK);
      RST = 1'b0;
      level = 0;
      repeat (3) begin
        @(posedge CLK);
        #1;
        vectors++;
        if (done !== 1'b0 || lanes_on !== 3'd0) begin
          miscompares++;
          $display("FAIL reset_mid_after done=%b lanes_on=%0d required 0/0", done, lanes_on);
        end
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int a, b;
    repeat (12) request($urandom_range(0, 7));
    repeat (4) begin
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      if (clamp_req(a) != level) begin
        send(a, ok);
        if (ok) begin
          run_model(level, clamp_req(a), 1'b1, b);
          @(posedge CLK);
          #1;
          req_valid = 1'b0;
          run_model(level, clamp_req(b), 1'b0, 0);
        end
      end else begin
        request(b);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    level = 0;
    test_reset();
    test_raise();
    test_same_level();
    test_lower();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
